// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the 12-state counter sequence checker: code table,
// successor and index lookups, and the sampling FSM encoding.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] Z_CODE        = 4'h4;
  localparam logic [3:0] ILLEGAL_INDEX = 4'hF;
  localparam int         SEQ_LEN       = 12;

  // Entry [i] is the code at sequence position i; position 11 wraps to 0.
  localparam logic [SEQ_LEN-1:0][3:0] SEQ_TABLE = {
    4'h7, 4'hF, 4'h1, 4'hC, 4'h2, 4'h6,
    4'h9, 4'hA, 4'h5, 4'hB, 4'h4, 4'h3
  };

  function automatic logic [3:0] index_of(input logic [3:0] code);
    logic [3:0] idx;
    idx = ILLEGAL_INDEX;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ_TABLE[i] == code) idx = i[3:0];
    end
    return idx;
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return index_of(code) == ILLEGAL_INDEX;
  endfunction

  // Illegal codes have no successor and map to 0x0, which is itself illegal
  // and therefore never matches a sampled legal code.
  function automatic logic [3:0] succ_of(input logic [3:0] code);
    logic [3:0] idx;
    logic [3:0] nxt;
    idx = index_of(code);
    nxt = 4'h0;
    if (idx != ILLEGAL_INDEX) begin
      if (idx == 4'd11) nxt = SEQ_TABLE[0];
      else              nxt = SEQ_TABLE[idx + 4'd1];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser for signals crossing into the system clock.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fsm_sequence_checker.sv
// Monitors the 12-state jammable counter: samples each step after a settle
// delay, checks it against the legal successor, counts laps, latches errors.
module fsm_sequence_checker
  import fsm_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int LAP_W         = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clk_Q,
  input  logic             Qa,
  input  logic             Qb,
  input  logic             Qc,
  input  logic             Qd,
  input  logic             JAM_Enable,
  input  logic             Err_Clear,
  output logic             Locked,
  output logic             Seq_Error,
  output logic [3:0]       Err_Expected,
  output logic [3:0]       Err_Actual,
  output logic             Illegal_Code,
  output logic [3:0]       State_Index,
  output logic [LAP_W-1:0] Lap_Count,
  output logic             Z_Seen
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic       clkq_s;
  logic       clkq_prev;
  logic       jam_s;
  logic [3:0] q_s;
  logic       step_edge;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       jam_flag;
  logic       jam_flag_next;
  logic       do_sample;

  logic [3:0] ref_code;
  logic [3:0] expected;
  logic       code_illegal;
  logic       checked;
  logic       mismatch;
  logic       new_error;
  logic       lap_hit;

  sync_2ff #(.WIDTH(1)) u_sync_clkq (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (Clk_Q),
    .q     (clkq_s)
  );

  sync_2ff #(.WIDTH(1)) u_sync_jam (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (JAM_Enable),
    .q     (jam_s)
  );

  sync_2ff #(.WIDTH(4)) u_sync_q (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     ({Qd, Qc, Qb, Qa}),
    .q     (q_s)
  );

  assign step_edge = clkq_s & ~clkq_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clkq_prev <= 1'b0;
      state     <= IDLE;
      cnt       <= 4'd0;
      jam_flag  <= 1'b0;
    end else begin
      clkq_prev <= clkq_s;
      state     <= state_next;
      cnt       <= cnt_next;
      jam_flag  <= jam_flag_next;
    end
  end

  // Steps arriving outside IDLE are dropped rather than queued.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    jam_flag_next = jam_flag;
    do_sample     = 1'b0;
    case (state)
      IDLE: begin
        if (step_edge) begin
          jam_flag_next = jam_s;
          cnt_next      = SETTLE_LOAD;
          state_next    = SETTLE;
        end
      end
      SETTLE: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = SAMPLE;
      end
      SAMPLE: begin
        do_sample  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Successors are always legal, so an illegal code while locked falls out
  // of the plain mismatch test.
  always_comb begin
    expected     = succ_of(ref_code);
    code_illegal = is_illegal(q_s);
    mismatch     = (q_s != expected);
    checked      = do_sample & Locked & ~jam_flag;
    new_error    = checked & mismatch;
    lap_hit      = checked & ~mismatch & (q_s == Z_CODE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ref_code     <= 4'h0;
      Locked       <= 1'b0;
      Illegal_Code <= 1'b0;
      State_Index  <= ILLEGAL_INDEX;
    end else if (do_sample) begin
      ref_code     <= q_s;
      Illegal_Code <= code_illegal;
      State_Index  <= index_of(q_s);
      if (!checked || mismatch) Locked <= ~code_illegal;
    end
  end

  // A new error outranks a simultaneous clear and captures fresh values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Seq_Error    <= 1'b0;
      Err_Expected <= 4'h0;
      Err_Actual   <= 4'h0;
    end else if (new_error) begin
      Seq_Error <= 1'b1;
      if (!Seq_Error || Err_Clear) begin
        Err_Expected <= expected;
        Err_Actual   <= q_s;
      end
    end else if (Err_Clear) begin
      Seq_Error    <= 1'b0;
      Err_Expected <= 4'h0;
      Err_Actual   <= 4'h0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Lap_Count <= '0;
      Z_Seen    <= 1'b0;
    end else begin
      Z_Seen <= lap_hit;
      if (Err_Clear)    Lap_Count <= lap_hit ? LAP_W'(1) : '0;
      else if (lap_hit) Lap_Count <= Lap_Count + LAP_W'(1);
    end
  end

endmodule

// File: tb/tb_fsm_sequence_checker.sv
// Bench for fsm_sequence_checker: table of clean steps plus hand sequences
// for errors, jams, clears, dropped edges and reset during settle.
module tb_fsm_sequence_checker;

  typedef struct {
    logic [3:0] code;
    logic       jam;
    logic       clr;
    logic       dbl;
    logic       locked;
    logic       seq_err;
    logic [3:0] e_exp;
    logic [3:0] e_act;
    logic       illegal;
    logic [3:0] index;
    logic [7:0] lap;
  } vec_t;

  localparam logic [3:0] SEQ [12] = '{4'h3, 4'h4, 4'hB, 4'h5, 4'hA, 4'h9,
                                      4'h6, 4'h2, 4'hC, 4'h1, 4'hF, 4'h7};

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Clk_Q;
  logic       Qa, Qb, Qc, Qd;
  logic       JAM_Enable;
  logic       Err_Clear;
  logic       Locked;
  logic       Seq_Error;
  logic [3:0] Err_Expected;
  logic [3:0] Err_Actual;
  logic       Illegal_Code;
  logic [3:0] State_Index;
  logic [7:0] Lap_Count;
  logic       Z_Seen;

  int   checks  = 0;
  int   passed  = 0;
  int   z_count = 0;
  int   step_no = 0;
  vec_t table1 [24];
  vec_t exp_q [$];

  always #5 Clk = ~Clk;

  fsm_sequence_checker #(.SETTLE_CYCLES(4), .LAP_W(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Clk_Q        (Clk_Q),
    .Qa           (Qa),
    .Qb           (Qb),
    .Qc           (Qc),
    .Qd           (Qd),
    .JAM_Enable   (JAM_Enable),
    .Err_Clear    (Err_Clear),
    .Locked       (Locked),
    .Seq_Error    (Seq_Error),
    .Err_Expected (Err_Expected),
    .Err_Actual   (Err_Actual),
    .Illegal_Code (Illegal_Code),
    .State_Index  (State_Index),
    .Lap_Count    (Lap_Count),
    .Z_Seen       (Z_Seen)
  );

  always @(negedge Clk) if (Z_Seen === 1'b1) z_count++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t makeVec(logic [3:0] code, logic jam, logic clr, logic dbl,
                                   logic locked, logic seq_err, logic [3:0] e_exp,
                                   logic [3:0] e_act, logic illegal, logic [3:0] index,
                                   logic [7:0] lap);
    vec_t v;
    v.code = code; v.jam = jam; v.clr = clr; v.dbl = dbl; v.locked = locked;
    v.seq_err = seq_err; v.e_exp = e_exp; v.e_act = e_act; v.illegal = illegal;
    v.index = index; v.lap = lap;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual === required) passed++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
  endtask

  task automatic compareResult();
    vec_t e;
    string p;
    p = $sformatf("step%0d", step_no);
    if (exp_q.size() == 0) begin
      checkOutput({p, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({p, "_locked"},  Locked,       e.locked);
    checkOutput({p, "_seq_err"}, Seq_Error,    e.seq_err);
    checkOutput({p, "_err_exp"}, Err_Expected, e.e_exp);
    checkOutput({p, "_err_act"}, Err_Actual,   e.e_act);
    checkOutput({p, "_illegal"}, Illegal_Code, e.illegal);
    checkOutput({p, "_index"},   State_Index,  e.index);
    checkOutput({p, "_lap"},     Lap_Count,    e.lap);
  endtask

  // One counter step: Q settles first, Clk_Q rises just after edge 0 and the
  // evaluated result is registered by edge 8.
  task automatic applyStimulus(input vec_t v);
    step_no++;
    exp_q.push_back(v);
    @(posedge Clk); #1;
    {Qd, Qc, Qb, Qa} = v.code;
    JAM_Enable = v.jam;
    repeat (3) @(posedge Clk);
    #1 Clk_Q = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge Clk); #1;
      if (v.dbl && e == 1) Clk_Q = 1'b0;
      if (v.dbl && e == 2) Clk_Q = 1'b1;
      if (e == 7) Err_Clear = v.clr;
      if (e == 8) Err_Clear = 1'b0;
    end
    compareResult();
    Clk_Q = 1'b0;
    JAM_Enable = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, "_locked"},  Locked,       0);
    checkOutput({p, "_seq_err"}, Seq_Error,    0);
    checkOutput({p, "_err_exp"}, Err_Expected, 0);
    checkOutput({p, "_err_act"}, Err_Actual,   0);
    checkOutput({p, "_illegal"}, Illegal_Code, 0);
    checkOutput({p, "_index"},   State_Index,  4'hF);
    checkOutput({p, "_lap"},     Lap_Count,    0);
    checkOutput({p, "_z_seen"},  Z_Seen,       0);
  endtask

  initial begin
    int z_before;
    for (int i = 0; i < 24; i++) begin
      table1[i] = makeVec(SEQ[i % 12], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0,
                          1'b0, 4'(i % 12), (i >= 13) ? 8'd2 : ((i >= 1) ? 8'd1 : 8'd0));
    end

    Reset_n = 1'b0; Clk_Q = 1'b0; JAM_Enable = 1'b0; Err_Clear = 1'b0;
    {Qd, Qc, Qb, Qa} = 4'h0;
    repeat (3) @(posedge Clk);
    #1 checkResetValues("reset");
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);

    z_before = z_count;
    for (int i = 0; i < 24; i++) applyStimulus(table1[i]);
    checkOutput("laps_z_pulses", z_count - z_before, 2);

    applyStimulus(makeVec(4'h3, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd0, 8'd2));
    applyStimulus(makeVec(4'h4, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd1, 8'd3));
    applyStimulus(makeVec(4'hB, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd2, 8'd3));
    applyStimulus(makeVec(4'hA, 0, 0, 0, 1, 1, 4'h5, 4'hA, 0, 4'd4, 8'd3));
    applyStimulus(makeVec(4'h9, 0, 0, 0, 1, 1, 4'h5, 4'hA, 0, 4'd5, 8'd3));
    applyStimulus(makeVec(4'h6, 0, 0, 0, 1, 1, 4'h5, 4'hA, 0, 4'd6, 8'd3));

    @(posedge Clk); #1 Err_Clear = 1'b1;
    @(posedge Clk); #1 Err_Clear = 1'b0;
    checkOutput("clear_seq_err", Seq_Error, 0);
    checkOutput("clear_lap", Lap_Count, 0);
    checkOutput("clear_err_exp", Err_Expected, 0);
    checkOutput("clear_err_act", Err_Actual, 0);
    checkOutput("clear_keeps_locked", Locked, 1);

    applyStimulus(makeVec(4'h1, 1, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd9,  8'd0));
    applyStimulus(makeVec(4'hF, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd10, 8'd0));
    applyStimulus(makeVec(4'h7, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd11, 8'd0));
    applyStimulus(makeVec(4'h3, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd0,  8'd0));
    applyStimulus(makeVec(4'h4, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd1,  8'd1));

    applyStimulus(makeVec(4'hD, 1, 0, 0, 0, 0, 4'h0, 4'h0, 1, 4'hF, 8'd1));
    applyStimulus(makeVec(4'h3, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd0, 8'd1));

    applyStimulus(makeVec(4'h4, 0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 4'd1, 8'd1));
    applyStimulus(makeVec(4'h3, 0, 0, 0, 1, 1, 4'hB, 4'h3, 0, 4'd0, 8'd1));
    applyStimulus(makeVec(4'h5, 0, 1, 0, 1, 1, 4'h4, 4'h5, 0, 4'd3, 8'd0));
    @(posedge Clk); #1 Err_Clear = 1'b1;
    @(posedge Clk); #1 Err_Clear = 1'b0;
    checkOutput("clear2_seq_err", Seq_Error, 0);
    checkOutput("clear2_err_exp", Err_Expected, 0);

    z_before = z_count;
    applyStimulus(makeVec(4'hA, 0, 0, 1, 1, 0, 4'h0, 4'h0, 0, 4'd4, 8'd0));
    repeat (12) @(posedge Clk);
    #1 checkOutput("dbl_no_second_eval_err", Seq_Error, 0);
    checkOutput("dbl_no_second_eval_index", State_Index, 4);

    @(posedge Clk); #1 {Qd, Qc, Qb, Qa} = 4'h2;
    repeat (3) @(posedge Clk);
    #1 Clk_Q = 1'b1;
    repeat (5) @(posedge Clk);
    #1 Reset_n = 1'b0; Clk_Q = 1'b0;
    #1 checkResetValues("midreset");
    @(posedge Clk); #1 Reset_n = 1'b1;
    repeat (12) @(posedge Clk);
    #1 checkOutput("midreset_no_eval_index", State_Index, 4'hF);
    checkOutput("midreset_no_eval_locked", Locked, 0);
    applyStimulus(makeVec(4'h9, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd5, 8'd0));
    applyStimulus(makeVec(4'h6, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'd6, 8'd0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
